// File: rtl/rx_word_assembler.sv
// rx_word_assembler: packs pairs of UART bytes into 16-bit words.
// The first byte is held in a latch; the second byte completes the word,
// which is offered on a valid/ready output register. A half-received word is
// discarded if the second byte does not arrive within TIMEOUT_CYCLES cycles,
// and a completed word that finds the output register full is dropped and
// flagged on the sticky o_Overrun.
module rx_word_assembler #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter bit HI_FIRST       = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_RxDone,
    input  logic [7:0]  i_RxData,
    output logic        o_WordValid,
    output logic [15:0] o_Word,
    input  logic        i_WordReady,
    output logic        o_Overrun,
    output logic        o_Timeout,
    input  logic        i_ClrErr
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HALF = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    latch_q, latch_d;
    logic [15:0]   word_q, word_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
    logic          to_q, to_d;

    logic          complete;
    logic          consume;
    logic [15:0]   new_word;

    // Byte-pairing FSM with the inter-byte timeout counter
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_d  = latch_q;
        to_d     = 1'b0;
        complete = 1'b0;
        new_word = HI_FIRST ? {latch_q, i_RxData} : {i_RxData, latch_q};
        case (state_q)
            ST_IDLE: begin
                if (i_RxDone) begin
                    latch_d = i_RxData;
                    cnt_d   = '0;
                    state_d = ST_HALF;
                end
            end
            default: begin
                // A byte on the expiry cycle takes priority over the timeout
                if (i_RxDone) begin
                    complete = 1'b1;
                    latch_d  = '0;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    latch_d = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // Output register, handshake and sticky overrun flag
    always_comb begin
        consume = valid_q && i_WordReady;
        word_d  = word_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (complete && (!valid_q || consume)) begin
            word_d  = new_word;
            valid_d = 1'b1;
        end else if (consume) begin
            valid_d = 1'b0;
        end
        // Setting wins over a simultaneous clear
        if (complete && valid_q && !consume) begin
            ovr_d = 1'b1;
        end else if (i_ClrErr) begin
            ovr_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            latch_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
        end
    end

    assign o_Word      = word_q;
    assign o_WordValid = valid_q;
    assign o_Overrun   = ovr_q;
    assign o_Timeout   = to_q;

endmodule

// File: tb/tb_rx_word_assembler.sv
// Testbench for rx_word_assembler: two instances (high-first and low-first
// byte order) share one stimulus stream and are compared every cycle against
// a transaction-level reference model, plus directed scenario checks.
module tb_rx_word_assembler;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        ready = 1'b0;
    logic        clr = 1'b0;

    logic        hi_valid, lo_valid;
    logic [15:0] hi_word, lo_word;
    logic        hi_ovr, lo_ovr;
    logic        hi_to, lo_to;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    bit          m_pending;
    logic [7:0]  m_first;
    int          m_first_cyc;
    int          m_cyc;
    bit          m_valid;
    logic [15:0] m_word_hi, m_word_lo;
    bit          m_ovr;
    bit          m_to;

    rx_word_assembler #(.TIMEOUT_CYCLES(TO), .HI_FIRST(1'b1)) dut_hi (
        .clk(clk), .reset(reset), .i_RxDone(rx_done), .i_RxData(rx_data),
        .o_WordValid(hi_valid), .o_Word(hi_word), .i_WordReady(ready),
        .o_Overrun(hi_ovr), .o_Timeout(hi_to), .i_ClrErr(clr));

    rx_word_assembler #(.TIMEOUT_CYCLES(TO), .HI_FIRST(1'b0)) dut_lo (
        .clk(clk), .reset(reset), .i_RxDone(rx_done), .i_RxData(rx_data),
        .o_WordValid(lo_valid), .o_Word(lo_word), .i_WordReady(ready),
        .o_Overrun(lo_ovr), .o_Timeout(lo_to), .i_ClrErr(clr));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending = 0; m_first = '0; m_first_cyc = 0;
        m_valid = 0; m_word_hi = '0; m_word_lo = '0; m_ovr = 0; m_to = 0;
    endtask

    // One clock edge of the behavioural model: a word is a pair of bytes whose
    // second byte arrives no more than TO cycles after the first.
    task automatic model_step(input bit rx, input logic [7:0] d, input bit rdy, input bit cl);
        bit complete, to, consumed, ovr_set;
        complete = 0; to = 0; ovr_set = 0;
        consumed = m_valid && rdy;
        if (!m_pending) begin
            if (rx) begin
                m_pending = 1; m_first = d; m_first_cyc = m_cyc;
            end
        end else if (rx) begin
            complete = 1; m_pending = 0;
        end else if (m_cyc - m_first_cyc == TO) begin
            to = 1; m_pending = 0;
        end
        if (complete) begin
            if (!m_valid || consumed) begin
                m_word_hi = {m_first, d};
                m_word_lo = {d, m_first};
                m_valid = 1;
            end else begin
                ovr_set = 1;
            end
        end else if (consumed) begin
            m_valid = 0;
        end
        if (ovr_set) m_ovr = 1;
        else if (cl) m_ovr = 0;
        m_to = to;
        m_cyc++;
    endtask

    task automatic compare_all();
        check("hi_valid", 16'(hi_valid), 16'(m_valid));
        check("hi_word",  hi_word, m_word_hi);
        check("hi_ovr",   16'(hi_ovr), 16'(m_ovr));
        check("hi_to",    16'(hi_to), 16'(m_to));
        check("lo_valid", 16'(lo_valid), 16'(m_valid));
        check("lo_word",  lo_word, m_word_lo);
        check("lo_ovr",   16'(lo_ovr), 16'(m_ovr));
        check("lo_to",    16'(lo_to), 16'(m_to));
    endtask

    // Called at a negedge: drive inputs, advance one edge, compare at next negedge
    task automatic step(input bit rx, input logic [7:0] d, input bit rdy, input bit cl);
        rx_done = rx; rx_data = d; ready = rdy; clr = cl;
        @(posedge clk);
        model_step(rx, d, rdy, cl);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), rdy, 1'b0);
    endtask

    task automatic do_reset();
        rx_done = 0; ready = 0; clr = 0;
        #1 reset = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        m_cyc = 0;
        model_reset();
        @(negedge clk);
        compare_all();
        @(negedge clk);
        reset = 1'b1;

        // T1 / T2: byte order on both instances
        step(1, 8'h12, 1, 0); step(1, 8'h34, 1, 0);
        check("t1_valid", 16'(hi_valid), 16'd1);
        check("t1_word",  hi_word, 16'h1234);
        step(1, 8'hAB, 1, 0); step(1, 8'hCD, 1, 0);
        check("t2_word",  lo_word, 16'hCDAB);
        idle(2, 1);

        // T3: backpressure and overrun
        step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0);
        step(1, 8'h03, 0, 0); step(1, 8'h04, 0, 0);
        check("t3_word", hi_word, 16'h0102);
        check("t3_ovr",  16'(hi_ovr), 16'd1);
        step(0, 8'h00, 0, 1);
        check("t3_clr",  16'(hi_ovr), 16'd0);
        idle(2, 1);

        // T4: timeout then a fresh word
        step(1, 8'h55, 1, 0);
        idle(TO - 1, 1);
        check("t4_pre", 16'(hi_to), 16'd0);
        idle(1, 1);
        check("t4_to", 16'(hi_to), 16'd1);
        step(1, 8'h66, 1, 0); step(1, 8'h77, 1, 0);
        check("t4_word", hi_word, 16'h6677);
        idle(2, 1);

        // T5: second byte on the expiry cycle; completion while being consumed
        step(1, 8'hA5, 1, 0);
        idle(TO - 1, 1);
        step(1, 8'h5A, 1, 0);
        check("t5_race_to",   16'(hi_to), 16'd0);
        check("t5_race_word", hi_word, 16'hA55A);
        idle(2, 1);
        step(1, 8'hC1, 0, 0); step(1, 8'hC2, 0, 0);
        step(1, 8'hD1, 0, 0); step(1, 8'hD2, 1, 0);
        check("t5_load_word", hi_word, 16'hD1D2);
        check("t5_load_ovr",  16'(hi_ovr), 16'd0);
        idle(2, 1);

        // T6: reset in the middle of a word
        step(1, 8'h99, 1, 0);
        do_reset();
        check("t6_valid", 16'(hi_valid), 16'd0);
        step(1, 8'h11, 1, 0); step(1, 8'h22, 1, 0);
        check("t6_word", hi_word, 16'h1122);

        // Randomised traffic: dense bytes, then sparse bytes to provoke timeouts
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 99) < 40, 8'($urandom), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 10);
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 99) < 7, 8'($urandom), $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 5);
        step(1, 8'h01, 1, 0);
        do_reset();
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 99) < 30, 8'($urandom), $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
